// File: rtl/pow2_log2_seq.sv
// Sequential exponent finder: serially scans an operand to report floor/ceil log2,
// a power-of-two flag and a zero flag over valid/ready handshakes.
module pow2_log2_seq #(
  parameter  int N  = 8,
  localparam int EW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] out_exp,
  output logic [EW:0]   out_clog2,
  output logic          out_pow2,
  output logic          out_zero
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t         state, state_next;
  logic [N-1:0]   sh, sh_next;
  logic [EW-1:0]  cnt, cnt_next;
  logic           sticky, sticky_next;
  logic [EW-1:0]  exp_next;
  logic [EW:0]    clog2_next;
  logic           pow2_next;
  logic           zero_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The scan stops once only the leading one remains; sticky remembers any lower ones shifted out.
  always_comb begin
    state_next  = state;
    sh_next     = sh;
    cnt_next    = cnt;
    sticky_next = sticky;
    exp_next    = out_exp;
    clog2_next  = out_clog2;
    pow2_next   = out_pow2;
    zero_next   = out_zero;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sh_next     = in_data;
          cnt_next    = '0;
          sticky_next = 1'b0;
          if (in_data == '0) begin
            zero_next  = 1'b1;
            pow2_next  = 1'b0;
            exp_next   = '0;
            clog2_next = '0;
            state_next = DONE;
          end else begin
            state_next = SCAN;
          end
        end
      end
      SCAN: begin
        if (sh == ONE) begin
          exp_next   = cnt;
          pow2_next  = ~sticky;
          clog2_next = {1'b0, cnt} + {{EW{1'b0}}, sticky};
          zero_next  = 1'b0;
          state_next = DONE;
        end else begin
          sticky_next = sticky | sh[0];
          sh_next     = sh >> 1;
          cnt_next    = cnt + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      out_exp   <= '0;
      out_clog2 <= '0;
      out_pow2  <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      state     <= state_next;
      sh        <= sh_next;
      cnt       <= cnt_next;
      sticky    <= sticky_next;
      out_exp   <= exp_next;
      out_clog2 <= clog2_next;
      out_pow2  <= pow2_next;
      out_zero  <= zero_next;
    end
  end

endmodule
